ps2_scancode_decoder: RTL and testbench

//  Consumes PS/2 set-2 scancode bytes from the PS/2 receiver and turns key presses into ASCII chars for the Morse encoder.

---
 rtl/ps2_scancode_decoder_pkg.sv | 46 ++++
 rtl/ps2_char_fifo.sv | 49 ++++
 rtl/ps2_scancode_decoder.sv | 115 +++++++++++
 tb/tb_ps2_scancode_decoder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared definitions for the PS/2 scancode decoder: prefix bytes, prefix-FSM
// state encoding and the set-2 make-code to ASCII table.
package ps2_scancode_decoder_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } ps2_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] ascii;
  } lookup_t;

  // Set-2 make code -> upper-case ASCII; valid=0 for codes we do not map.
  function automatic lookup_t scan_to_ascii(input logic [7:0] code);
    lookup_t r;
    r.valid = 1'b1;
    r.ascii = 8'h00;
    case (code)
      8'h1C: r.ascii = 8'h41;  8'h32: r.ascii = 8'h42;  8'h21: r.ascii = 8'h43;
      8'h23: r.ascii = 8'h44;  8'h24: r.ascii = 8'h45;  8'h2B: r.ascii = 8'h46;
      8'h34: r.ascii = 8'h47;  8'h33: r.ascii = 8'h48;  8'h43: r.ascii = 8'h49;
      8'h3B: r.ascii = 8'h4A;  8'h42: r.ascii = 8'h4B;  8'h4B: r.ascii = 8'h4C;
      8'h3A: r.ascii = 8'h4D;  8'h31: r.ascii = 8'h4E;  8'h44: r.ascii = 8'h4F;
      8'h4D: r.ascii = 8'h50;  8'h15: r.ascii = 8'h51;  8'h2D: r.ascii = 8'h52;
      8'h1B: r.ascii = 8'h53;  8'h2C: r.ascii = 8'h54;  8'h3C: r.ascii = 8'h55;
      8'h2A: r.ascii = 8'h56;  8'h1D: r.ascii = 8'h57;  8'h22: r.ascii = 8'h58;
      8'h35: r.ascii = 8'h59;  8'h1A: r.ascii = 8'h5A;
      8'h45: r.ascii = 8'h30;  8'h16: r.ascii = 8'h31;  8'h1E: r.ascii = 8'h32;
      8'h26: r.ascii = 8'h33;  8'h25: r.ascii = 8'h34;  8'h2E: r.ascii = 8'h35;
      8'h36: r.ascii = 8'h36;  8'h3D: r.ascii = 8'h37;  8'h3E: r.ascii = 8'h38;
      8'h46: r.ascii = 8'h39;
      8'h29: r.ascii = 8'h20;
      8'h5A: r.ascii = 8'h0D;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_char_fifo.sv
// Generic synchronous show-ahead FIFO. Pointers carry one extra wrap bit so
// full/empty are distinguishable. A write while full is only taken when a
// read frees a slot on the same edge. rd_data reads as zero when empty.
module ps2_char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             rd_fire;
  logic             wr_fire;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign rd_fire = rd_en && !empty;
  assign wr_fire = wr_en && (!full || rd_fire);
  assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  // Pointer update: each pointer advances on its accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_fire) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
      if (rd_fire) rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since empty masks stale data.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: prefix FSM (F0 break / E0 extended), make-code
// lookup, one pipeline register, char FIFO and an overflow pulse.
// Optional typematic-repeat filter enabled by defining REPEAT_FILTER_EN.
module ps2_scancode_decoder
  import ps2_scancode_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_strb,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       overflow
);

  ps2_state_t state_reg;
  ps2_state_t state_next;
  lookup_t    lookup;
  logic       make_hit;
  logic       accept;
  logic       pipe_valid_reg;
  logic [7:0] pipe_char_reg;
  logic       overflow_reg;
  logic       fifo_full;
  logic       fifo_empty;

  assign lookup = scan_to_ascii(in_data);

  // Prefix FSM next state; flags a mapped make code seen in S_IDLE.
  always_comb begin
    state_next = state_reg;
    make_hit   = 1'b0;
    if (in_strb) begin
      case (state_reg)
        S_IDLE: begin
          if (in_data == PS2_BREAK)    state_next = S_BRK;
          else if (in_data == PS2_EXT) state_next = S_EXT;
          else                         make_hit   = lookup.valid;
        end
        S_BRK:     state_next = S_IDLE;
        S_EXT:     state_next = (in_data == PS2_BREAK) ? S_EXT_BRK : S_IDLE;
        S_EXT_BRK: state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // Prefix FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

`ifdef REPEAT_FILTER_EN
  logic [7:0] last_make_reg;
  logic [7:0] last_make_next;

  // Repeat filter: drop a make equal to the last accepted one; a plain break
  // of that key re-arms it. Extended sequences never reach S_BRK.
  always_comb begin
    last_make_next = last_make_reg;
    accept         = make_hit && (in_data != last_make_reg);
    if (accept)
      last_make_next = in_data;
    else if (in_strb && (state_reg == S_BRK) && (in_data == last_make_reg))
      last_make_next = 8'h00;
  end

  // Last accepted make code register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_make_reg <= 8'h00;
    else        last_make_reg <= last_make_next;
  end
`else
  assign accept = make_hit;
`endif

  // Lookup pipeline register feeding the FIFO write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_reg <= 1'b0;
      pipe_char_reg  <= 8'h00;
    end else begin
      pipe_valid_reg <= accept;
      if (accept) pipe_char_reg <= lookup.ascii;
    end
  end

  // Overflow pulse: a pipelined char hit a full FIFO with no read to make room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_reg <= 1'b0;
    else        overflow_reg <= pipe_valid_reg && fifo_full && !(char_valid && char_ready);
  end

  ps2_char_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pipe_valid_reg),
    .wr_data (pipe_char_reg),
    .rd_en   (char_ready),
    .rd_data (char_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign char_valid = !fifo_empty;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Testbench for ps2_scancode_decoder: directed scancode sequences, a
// byte-level model of the decoder checked every cycle, and literal
// expectations for each directed scenario. Honours REPEAT_FILTER_EN.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_strb = 1'b0;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready = 1'b0;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_strb    (in_strb),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Independent scancode table built from the key lists.
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                   8'h3D, 8'h3E, 8'h46};
  logic [7:0] ascii_tab [256];

  initial begin
    for (int i = 0; i < 256; i++) ascii_tab[i] = 8'h00;
    for (int i = 0; i < 26; i++) ascii_tab[letter_codes[i]] = 8'h41 + 8'(i);
    for (int i = 0; i < 10; i++) ascii_tab[digit_codes[i]] = 8'h30 + 8'(i);
    ascii_tab[8'h29] = 8'h20;
    ascii_tab[8'h5A] = 8'h0D;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] exp_q[$];
  logic       pend_v = 1'b0;
  logic [7:0] pend_c = 8'h00;
  logic       m_brk = 1'b0;
  logic       m_ext = 1'b0;
  logic [7:0] m_last = 8'h00;
  logic       ovf_exp = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      pend_v = 1'b0; m_brk = 1'b0; m_ext = 1'b0; m_last = 8'h00; ovf_exp = 1'b0;
    end else begin
      logic [7:0] b;
      if (exp_q.size() > 0 && char_ready) void'(exp_q.pop_front());
      ovf_exp = 1'b0;
      if (pend_v) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(pend_c);
        else ovf_exp = 1'b1;
      end
      pend_v = 1'b0;
      if (in_strb) begin
        b = in_data;
        if (m_brk) begin
          if (!m_ext && b == m_last) m_last = 8'h00;
          m_brk = 1'b0;
          m_ext = 1'b0;
        end else if (b == 8'hF0) begin
          m_brk = 1'b1;
        end else if (m_ext) begin
          m_ext = 1'b0;
        end else if (b == 8'hE0) begin
          m_ext = 1'b1;
        end else if (ascii_tab[b] != 8'h00) begin
`ifdef REPEAT_FILTER_EN
          if (b != m_last) begin
            pend_v = 1'b1; pend_c = ascii_tab[b]; m_last = b;
          end
`else
          pend_v = 1'b1; pend_c = ascii_tab[b];
`endif
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("char_valid", {31'd0, char_valid}, {31'd0, exp_q.size() != 0});
    check("char_data", {24'd0, char_data}, {24'd0, (exp_q.size() != 0) ? exp_q[0] : 8'h00});
    check("overflow", {31'd0, overflow}, {31'd0, ovf_exp});
  end

  // Record characters consumed from the DUT and overflow pulses.
  logic [7:0] got[$];
  int ovf_count = 0;

  always @(posedge clk) begin
    if (rst_n && char_valid && char_ready) begin
      got.push_back(char_data);
      $display("pop char=%02h t=%0t", char_data, $time);
    end
  end

  always @(negedge clk) if (overflow) ovf_count++;

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_data = b;
    in_strb = 1'b1;
    @(negedge clk);
    in_strb = 1'b0;
    in_data = 8'h00;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    ovf_count = 0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n41;
    // Reset state.
    wait_cycles(2);
    check("reset_valid", {31'd0, char_valid}, 32'd0);
    check("reset_data", {24'd0, char_data}, 32'd0);
    check("reset_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    // T1: latency of a single make.
    char_ready = 1'b0;
    send(8'h1C);
    check("t1_valid_k", {31'd0, char_valid}, 32'd0);
    @(negedge clk);
    check("t1_valid_k1", {31'd0, char_valid}, 32'd1);
    check("t1_data", {24'd0, char_data}, 32'h41);
    char_ready = 1'b1;
    @(negedge clk);
    check("t1_drained", {31'd0, char_valid}, 32'd0);
    $display("txn T1 single make done");

    // T2: mixed sequence with a break pair.
    do_reset();
    char_ready = 1'b1;
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'h45); send(8'h29); send(8'h5A);
    wait_cycles(4);
    check("t2_count", got.size(), 32'd4);
    if (got.size() == 4) begin
      check("t2_c0", {24'd0, got[0]}, 32'h41);
      check("t2_c1", {24'd0, got[1]}, 32'h30);
      check("t2_c2", {24'd0, got[2]}, 32'h20);
      check("t2_c3", {24'd0, got[3]}, 32'h0D);
    end
    $display("txn T2 sequence done");

    // T3: extended keys and unmapped code dropped; FSM ends idle.
    do_reset();
    char_ready = 1'b1;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h0E);
    wait_cycles(3);
    check("t3_none", got.size(), 32'd0);
    send(8'h16);
    wait_cycles(3);
    check("t3_count", got.size(), 32'd1);
    if (got.size() == 1) check("t3_c0", {24'd0, got[0]}, 32'h31);
    $display("txn T3 extended done");

    // T4: overflow with ready low.
    do_reset();
    char_ready = 1'b0;
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    wait_cycles(3);
    check("t4_ovf_pulses", ovf_count, 32'd1);
    char_ready = 1'b1;
    wait_cycles(8);
    check("t4_count", got.size(), 32'd4);
    if (got.size() == 4) begin
      check("t4_c0", {24'd0, got[0]}, 32'h41);
      check("t4_c1", {24'd0, got[1]}, 32'h42);
      check("t4_c2", {24'd0, got[2]}, 32'h43);
      check("t4_c3", {24'd0, got[3]}, 32'h44);
    end
    $display("txn T4 overflow done");

    // T5: write into full FIFO accepted when read happens on the same edge.
    do_reset();
    char_ready = 1'b0;
    send(8'h2B); send(8'h34); send(8'h33); send(8'h43);
    wait_cycles(2);
    check("t5_full_valid", {31'd0, char_valid}, 32'd1);
    send(8'h3B);
    char_ready = 1'b1;
    wait_cycles(8);
    check("t5_ovf_pulses", ovf_count, 32'd0);
    check("t5_count", got.size(), 32'd5);
    if (got.size() == 5) begin
      check("t5_c0", {24'd0, got[0]}, 32'h46);
      check("t5_c3", {24'd0, got[3]}, 32'h49);
      check("t5_c4", {24'd0, got[4]}, 32'h4A);
    end
    $display("txn T5 full+read done");

    // T6: reset mid-break with chars buffered.
    do_reset();
    char_ready = 1'b0;
    send(8'h1C); send(8'h32);
    wait_cycles(2);
    check("t6_buffered", {31'd0, char_valid}, 32'd1);
    send(8'hF0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", {31'd0, char_valid}, 32'd0);
    check("t6_async_data", {24'd0, char_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    char_ready = 1'b1;
    send(8'h1C);
    wait_cycles(3);
    check("t6_count", got.size(), 32'd1);
    if (got.size() == 1) check("t6_c0", {24'd0, got[0]}, 32'h41);
    $display("txn T6 reset mid-sequence done");

    // T7: typematic repeat.
    do_reset();
    char_ready = 1'b1;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    wait_cycles(4);
    n41 = 0;
    foreach (got[i]) if (got[i] == 8'h41) n41++;
    check("t7_total", got.size(), 32'(n41));
`ifdef REPEAT_FILTER_EN
    check("t7_count_41", n41, 32'd2);
`else
    check("t7_count_41", n41, 32'd4);
`endif
    $display("txn T7 repeat done");

    wait_cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
